// File: rtl/shaper_cfg_ctrl_pkg.sv
// Shared constants, types and helpers for the shaper configuration sequencer.
// Imported by the legality checker and the sequencer top.
package shaper_cfg_ctrl_pkg;

  localparam int CHANNEL_SIZE          = 2;
  localparam int SIZE_SHAPER_CONSTANT  = 8;
  localparam int SIZE_SHAPER_SHIFT_REG = 300;
  localparam int NORM_MAX              = 26;
  localparam int QUIET_TIMEOUT         = 1000;

  localparam int CH_W  = (CHANNEL_SIZE > 1) ? $clog2(CHANNEL_SIZE) : 1;
  // One extra bit so k+l of two full-scale constants cannot wrap.
  localparam int SUM_W = SIZE_SHAPER_CONSTANT + 1;

  localparam int DEFAULT_K    = 25;
  localparam int DEFAULT_L    = 20;
  localparam int DEFAULT_NORM = 10;

  typedef struct packed {
    logic [SIZE_SHAPER_CONSTANT-1:0] k;
    logic [SIZE_SHAPER_CONSTANT-1:0] l;
    logic [SIZE_SHAPER_CONSTANT-1:0] norm;
  } shaper_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    APPLY,
    FLUSH
  } shaper_cfg_state_t;

  localparam shaper_cfg_t DEFAULT_CFG = '{
    k:    SIZE_SHAPER_CONSTANT'(DEFAULT_K),
    l:    SIZE_SHAPER_CONSTANT'(DEFAULT_L),
    norm: SIZE_SHAPER_CONSTANT'(DEFAULT_NORM)
  };

  function automatic logic [SUM_W-1:0] cfg_sum(input shaper_cfg_t c);
    return SUM_W'(c.k) + SUM_W'(c.l);
  endfunction

endpackage

// File: rtl/shaper_cfg_check.sv
// Combinational legality check of a shaper configuration request.
module shaper_cfg_check
  import shaper_cfg_ctrl_pkg::*;
(
  input  shaper_cfg_t      cfg,
  input  logic [CH_W-1:0]  channel,
  output logic             ok
);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = cfg_sum(cfg);
    ok  = (cfg.k != '0)
       && (cfg.l >= cfg.k)
       && (sum <= SUM_W'(SIZE_SHAPER_SHIFT_REG))
       && (cfg.norm <= SIZE_SHAPER_CONSTANT'(NORM_MAX))
       && (int'(channel) < CHANNEL_SIZE);
  end

endmodule

// File: rtl/shaper_cfg_ctrl.sv
// Run-time configuration sequencer: validates a request, waits for the target
// channel to go quiet, applies and clears it, then masks its output during refill.
module shaper_cfg_ctrl
  import shaper_cfg_ctrl_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [CH_W-1:0]                              cfg_channel,
  input  logic [SIZE_SHAPER_CONSTANT-1:0]              cfg_k,
  input  logic [SIZE_SHAPER_CONSTANT-1:0]              cfg_l,
  input  logic [SIZE_SHAPER_CONSTANT-1:0]              cfg_norm,
  input  logic [CHANNEL_SIZE-1:0]                      channel_busy,
  output logic [CHANNEL_SIZE*SIZE_SHAPER_CONSTANT-1:0] shaper_k,
  output logic [CHANNEL_SIZE*SIZE_SHAPER_CONSTANT-1:0] shaper_l,
  output logic [CHANNEL_SIZE*SIZE_SHAPER_CONSTANT-1:0] shaper_norm,
  output logic [CHANNEL_SIZE-1:0]                      shaper_clear,
  output logic [CHANNEL_SIZE-1:0]                      shaper_out_valid,
  output logic                                         cfg_done,
  output logic                                         cfg_forced,
  output logic                                         cfg_error
);

  shaper_cfg_state_t state;
  shaper_cfg_t       live_cfg [CHANNEL_SIZE];
  shaper_cfg_t       pend_cfg;
  logic [CH_W-1:0]   pend_ch;
  logic              forced;
  logic [15:0]       timer;
  logic [SUM_W-1:0]  flush_cnt;

  shaper_cfg_t req_cfg;
  logic        req_ok;

  assign req_cfg = '{k: cfg_k, l: cfg_l, norm: cfg_norm};

  shaper_cfg_check u_check (
    .cfg     (req_cfg),
    .channel (cfg_channel),
    .ok      (req_ok)
  );

  assign cfg_ready = (state == IDLE);

  for (genvar i = 0; i < CHANNEL_SIZE; i++) begin : g_pack
    assign shaper_k[i*SIZE_SHAPER_CONSTANT +: SIZE_SHAPER_CONSTANT]    = live_cfg[i].k;
    assign shaper_l[i*SIZE_SHAPER_CONSTANT +: SIZE_SHAPER_CONSTANT]    = live_cfg[i].l;
    assign shaper_norm[i*SIZE_SHAPER_CONSTANT +: SIZE_SHAPER_CONSTANT] = live_cfg[i].norm;
  end

  // NOTE: non-blocking assignments only here, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend_cfg  <= DEFAULT_CFG;
      pend_ch   <= '0;
      forced    <= 1'b0;
      timer     <= '0;
      flush_cnt <= '0;
      // NOTE: the live constant array is reset on purpose -- it is a handful of
      // flops, and an aborted sequence must not leave partial constants behind.
      for (int i = 0; i < CHANNEL_SIZE; i++) live_cfg[i] <= DEFAULT_CFG;
      shaper_clear     <= '0;
      shaper_out_valid <= '1;
      cfg_done         <= 1'b0;
      cfg_forced       <= 1'b0;
      cfg_error        <= 1'b0;
    end else begin
      shaper_clear <= '0;
      cfg_done     <= 1'b0;
      cfg_forced   <= 1'b0;
      cfg_error    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (req_ok) begin
              pend_cfg <= req_cfg;
              pend_ch  <= cfg_channel;
              forced   <= 1'b0;
              timer    <= '0;
              state    <= WAIT_QUIET;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end

        WAIT_QUIET: begin
          // Busy still high at the last timer value means the apply is forced.
          if (!channel_busy[pend_ch] || timer == 16'(QUIET_TIMEOUT - 1)) begin
            forced                    <= channel_busy[pend_ch];
            shaper_clear[pend_ch]     <= 1'b1;
            shaper_out_valid[pend_ch] <= 1'b0;
            state                     <= APPLY;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        APPLY: begin
          live_cfg[pend_ch] <= pend_cfg;
          flush_cnt         <= cfg_sum(pend_cfg);
          state             <= FLUSH;
        end

        FLUSH: begin
          if (flush_cnt == SUM_W'(1)) begin
            shaper_out_valid[pend_ch] <= 1'b1;
            cfg_done                  <= 1'b1;
            cfg_forced                <= forced;
            state                     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - SUM_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shaper_cfg_ctrl.sv
// Directed bench for shaper_cfg_ctrl: apply timing, rejection, timeout,
// reset abort and back-to-back requests with hand-computed cycle numbers.
module tb_shaper_cfg_ctrl;
  import shaper_cfg_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [CH_W-1:0] cfg_channel;
  logic [7:0]  cfg_k, cfg_l, cfg_norm;
  logic [1:0]  channel_busy;
  logic [15:0] shaper_k, shaper_l, shaper_norm;
  logic [1:0]  shaper_clear, shaper_out_valid;
  logic        cfg_done, cfg_forced, cfg_error;

  int total = 0;
  int bad   = 0;

  shaper_cfg_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_channel      (cfg_channel),
    .cfg_k            (cfg_k),
    .cfg_l            (cfg_l),
    .cfg_norm         (cfg_norm),
    .channel_busy     (channel_busy),
    .shaper_k         (shaper_k),
    .shaper_l         (shaper_l),
    .shaper_norm      (shaper_norm),
    .shaper_clear     (shaper_clear),
    .shaper_out_valid (shaper_out_valid),
    .cfg_done         (cfg_done),
    .cfg_forced       (cfg_forced),
    .cfg_error        (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int kof(input int ch);
    return int'(shaper_k[ch*8 +: 8]);
  endfunction
  function automatic int lof(input int ch);
    return int'(shaper_l[ch*8 +: 8]);
  endfunction
  function automatic int nof(input int ch);
    return int'(shaper_norm[ch*8 +: 8]);
  endfunction

  // Presents a request during cycle 0 and returns in cycle 1 with valid dropped.
  task automatic send(input int ch, input int k, input int l, input int n);
    cfg_valid   = 1'b1;
    cfg_channel = CH_W'(ch);
    cfg_k       = 8'(k);
    cfg_l       = 8'(l);
    cfg_norm    = 8'(n);
    step();
    cfg_valid   = 1'b0;
  endtask

  task automatic check_cfg(input string tag, input int ch, input int k, input int l, input int n);
    check({tag, "_k"}, kof(ch), k);
    check({tag, "_l"}, lof(ch), l);
    check({tag, "_norm"}, nof(ch), n);
  endtask

  // Watches one accepted request from cycle 1; target busy is high in cycles <= busy_until.
  task automatic observe(input int ch, input int busy_until, input int budget,
                         output int apply_c, output int low_cnt, output int done_c,
                         output int forced_v, output int old_k, output int new_k,
                         output int other_bad);
    apply_c = -1; low_cnt = 0; done_c = -1; forced_v = -1;
    old_k = -1; new_k = -1; other_bad = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      channel_busy[ch] = (cyc <= busy_until);
      if (shaper_clear[ch] && apply_c < 0) begin
        apply_c = cyc;
        old_k   = kof(ch);
      end
      if (apply_c >= 0 && cyc == apply_c + 1) new_k = kof(ch);
      if (!shaper_out_valid[ch]) low_cnt++;
      if (!shaper_out_valid[1-ch]) other_bad++;
      if (cfg_done) begin
        done_c   = cyc;
        forced_v = int'(cfg_forced);
        break;
      end
      step();
    end
    channel_busy[ch] = 1'b0;
  endtask

  int apply_c, low_cnt, done_c, forced_v, old_k, new_k, other_bad;

  initial begin
    int bad_k [5];
    int bad_l [5];
    int bad_n [5];
    int done_seen, err_seen;
    int done1, done2, xfer_c, clear0_c;
    bad_k = '{30, 0, 25, 151, 255};
    bad_l = '{20, 20, 25, 150, 255};
    bad_n = '{10, 10, 27, 10, 10};

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_channel = '0;
    cfg_k = '0; cfg_l = '0; cfg_norm = '0; channel_busy = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    check("rst_ready", cfg_ready, 1);
    check("rst_out_valid", shaper_out_valid, 2'b11);
    check("rst_clear", shaper_clear, 0);
    check("rst_flags", {cfg_done, cfg_forced, cfg_error}, 0);
    check_cfg("rst_ch0", 0, 25, 20, 10);
    check_cfg("rst_ch1", 1, 25, 20, 10);

    // ch1 quiet, ch0 busy (must be ignored)
    channel_busy[0] = 1'b1;
    send(1, 10, 15, 8);
    check("t1_ready_low", cfg_ready, 0);
    observe(1, 0, 60, apply_c, low_cnt, done_c, forced_v, old_k, new_k, other_bad);
    channel_busy[0] = 1'b0;
    check("t1_apply_cycle", apply_c, 2);
    check("t1_k_at_apply", old_k, 25);
    check("t1_k_after_apply", new_k, 10);
    check("t1_low_cycles", low_cnt, 26);
    check("t1_done_cycle", done_c, 28);
    check("t1_forced", forced_v, 0);
    check("t1_ch0_valid", other_bad, 0);
    check("t1_ready_at_done", cfg_ready, 1);
    check("t1_valid_at_done", shaper_out_valid, 2'b11);
    check_cfg("t1_ch1", 1, 10, 15, 8);
    check_cfg("t1_ch0", 0, 25, 20, 10);
    step();
    check("t1_done_pulse", cfg_done, 0);

    // illegal requests on ch0
    for (int i = 0; i < 5; i++) begin
      send(0, bad_k[i], bad_l[i], bad_n[i]);
      check($sformatf("t2_err_%0d", i), cfg_error, 1);
      check($sformatf("t2_ready_%0d", i), cfg_ready, 1);
      check($sformatf("t2_valid_%0d", i), shaper_out_valid, 2'b11);
      step();
      check($sformatf("t2_err_pulse_%0d", i), cfg_error, 0);
      check_cfg($sformatf("t2_ch0_%0d", i), 0, 25, 20, 10);
    end

    // k+l at the delay-line depth
    send(0, 150, 150, 5);
    check("t3_no_err", cfg_error, 0);
    observe(0, 0, 400, apply_c, low_cnt, done_c, forced_v, old_k, new_k, other_bad);
    check("t3_apply_cycle", apply_c, 2);
    check("t3_low_cycles", low_cnt, 301);
    check("t3_done_cycle", done_c, 303);
    check_cfg("t3_ch0", 0, 150, 150, 5);
    step();

    // busy for cycles 1..40
    send(0, 4, 6, 2);
    observe(0, 40, 200, apply_c, low_cnt, done_c, forced_v, old_k, new_k, other_bad);
    check("t4a_apply_cycle", apply_c, 42);
    check("t4a_low_cycles", low_cnt, 11);
    check("t4a_done_cycle", done_c, 53);
    check("t4a_forced", forced_v, 0);
    step();

    // busy stuck high: timeout forces the apply
    send(0, 5, 6, 3);
    observe(0, 100000, 1100, apply_c, low_cnt, done_c, forced_v, old_k, new_k, other_bad);
    check("t4b_apply_cycle", apply_c, 1001);
    check("t4b_low_cycles", low_cnt, 12);
    check("t4b_done_cycle", done_c, 1013);
    check("t4b_forced", forced_v, 1);
    check_cfg("t4b_ch0", 0, 5, 6, 3);
    step();
    check("t4b_forced_pulse", cfg_forced, 0);

    // reset in the middle of a ch1 flush
    send(1, 10, 15, 8);
    repeat (4) step();
    check("t5_in_flush_valid", shaper_out_valid, 2'b01);
    check("t5_in_flush_k", kof(1), 10);
    reset_n = 1'b0;
    #2;
    check_cfg("t5_rst_ch1", 1, 25, 20, 10);
    check_cfg("t5_rst_ch0", 0, 25, 20, 10);
    check("t5_rst_valid", shaper_out_valid, 2'b11);
    check("t5_rst_clear", shaper_clear, 0);
    step();
    reset_n = 1'b1;
    step();
    check("t5_ready", cfg_ready, 1);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (cfg_done) done_seen++;
      step();
    end
    check("t5_no_done", done_seen, 0);
    check("t5_k_after", kof(1), 25);

    // second request held valid while the first is in flight
    send(1, 2, 3, 1);
    done1 = -1; done2 = -1; xfer_c = -1; clear0_c = -1; err_seen = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (xfer_c < 0) begin
        cfg_valid = 1'b1; cfg_channel = CH_W'(0);
        cfg_k = 8'd3; cfg_l = 8'd4; cfg_norm = 8'd2;
      end
      if (cfg_error) err_seen++;
      if (shaper_clear[0] && clear0_c < 0) clear0_c = cyc;
      if (cfg_done) begin
        if (done1 < 0) done1 = cyc;
        else if (done2 < 0) done2 = cyc;
      end
      if (xfer_c < 0 && cfg_valid && cfg_ready) xfer_c = cyc;
      if (done2 >= 0) break;
      step();
      if (xfer_c >= 0) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    check("t6_first_done", done1, 8);
    check("t6_xfer_cycle", xfer_c, 8);
    check("t6_second_apply", clear0_c, 10);
    check("t6_second_done", done2, 18);
    check("t6_no_error", err_seen, 0);
    check_cfg("t6_ch1", 1, 2, 3, 1);
    check_cfg("t6_ch0", 0, 3, 4, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
